mem_bus_ctrl: RTL and testbench

Memory bus controller between the CPU core's memory port and the external 16-bit asynchronous SRAM. It turns the core's single-word read and write requests into SRAM strobe sequences with a configurable number of wait states. It also decodes one memory-mapped I/O word that holds the value shown on the seven-segment display. The controller returns a one-cycle `cpu_ready` pulse, which the core's Fetch and Memory states wait on.

---
 rtl/mem_bus_ctrl_if.sv | 30 +++
 rtl/mem_bus_ctrl.sv | 138 +++++++++++++
 tb/tb_mem_bus_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_ctrl_if.sv
// Bus bundle between the CPU memory port, the controller and the external SRAM.
// The slave side is the controller; the master side plays the core and the SRAM.
interface mem_bus_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [23:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic [23:0] mem_addr;
  logic [15:0] mem_dq_out;
  logic        mem_dq_oe;
  logic [15:0] mem_dq_in;
  logic        mem_ce_n;
  logic        mem_oe_n;
  logic        mem_we_n;
  logic [15:0] io_value;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_dq_in,
    output cpu_rdata, cpu_ready, mem_addr, mem_dq_out, mem_dq_oe,
           mem_ce_n, mem_oe_n, mem_we_n, io_value
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_dq_in,
    input  cpu_rdata, cpu_ready, mem_addr, mem_dq_out, mem_dq_oe,
           mem_ce_n, mem_oe_n, mem_we_n, io_value
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Turns single-word core requests into async SRAM strobe sequences with WAIT_CYCLES
// wait states, and decodes one I/O word holding the seven-segment display value.
//
// state  | meaning
// IDLE   | waiting for cpu_req; captures the request
// ACCESS | SRAM strobes active, wait counter running
// HOLD   | write recovery: data still driven one cycle after we_n rises
// DONE   | transaction finished; cpu_ready pulses on the way out
module mem_bus_ctrl #(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [23:0] IO_ADDR     = 24'hFFFFFF
) (
  input logic           clk,
  input logic           reset,
  mem_bus_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, HOLD, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        we_q, we_nxt;
  logic [23:0] addr_q, addr_nxt;
  logic [15:0] dq_out_q, dq_out_nxt;
  logic [15:0] rdata_q, rdata_nxt;
  logic [15:0] io_q, io_nxt;
  logic        dq_oe_q, dq_oe_nxt;
  logic        ce_n_q, ce_n_nxt;
  logic        oe_n_q, oe_n_nxt;
  logic        we_n_q, we_n_nxt;
  logic        ready_q, ready_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      dq_out_q <= '0;
      rdata_q  <= '0;
      io_q     <= '0;
      dq_oe_q  <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      we_q     <= we_nxt;
      addr_q   <= addr_nxt;
      dq_out_q <= dq_out_nxt;
      rdata_q  <= rdata_nxt;
      io_q     <= io_nxt;
      dq_oe_q  <= dq_oe_nxt;
      ce_n_q   <= ce_n_nxt;
      oe_n_q   <= oe_n_nxt;
      we_n_q   <= we_n_nxt;
      ready_q  <= ready_nxt;
    end
  end

  // Every output is a register, so cpu_ready lands one edge after DONE is entered.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    we_nxt     = we_q;
    addr_nxt   = addr_q;
    dq_out_nxt = dq_out_q;
    rdata_nxt  = rdata_q;
    io_nxt     = io_q;
    dq_oe_nxt  = dq_oe_q;
    ce_n_nxt   = ce_n_q;
    oe_n_nxt   = oe_n_q;
    we_n_nxt   = we_n_q;
    ready_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cpu_req) begin
          we_nxt  = bus.cpu_we;
          cnt_nxt = CNT_LOAD;
          if (bus.cpu_addr == IO_ADDR) begin
            state_nxt = DONE;
            if (bus.cpu_we) io_nxt = bus.cpu_wdata;
            else            rdata_nxt = io_q;
          end else begin
            state_nxt = ACCESS;
            addr_nxt  = bus.cpu_addr;
            ce_n_nxt  = 1'b0;
            if (bus.cpu_we) begin
              we_n_nxt   = 1'b0;
              dq_oe_nxt  = 1'b1;
              dq_out_nxt = bus.cpu_wdata;
            end else begin
              oe_n_nxt = 1'b0;
            end
          end
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          if (we_q) begin
            we_n_nxt  = 1'b1;
            state_nxt = HOLD;
          end else begin
            rdata_nxt = bus.mem_dq_in;
            ce_n_nxt  = 1'b1;
            oe_n_nxt  = 1'b1;
            state_nxt = DONE;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      HOLD: begin
        ce_n_nxt  = 1'b1;
        dq_oe_nxt = 1'b0;
        state_nxt = DONE;
      end
      DONE: begin
        ready_nxt = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cpu_rdata  = rdata_q;
  assign bus.cpu_ready  = ready_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_dq_out = dq_out_q;
  assign bus.mem_dq_oe  = dq_oe_q;
  assign bus.mem_ce_n   = ce_n_q;
  assign bus.mem_oe_n   = oe_n_q;
  assign bus.mem_we_n   = we_n_q;
  assign bus.io_value   = io_q;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: one controller with 3 wait states, one with 1,
// each talking to a small SRAM model.
module tb_mem_bus_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic preload;
  always #5 clk = ~clk;

  logic [1:0]  req, we;
  logic [23:0] addr  [2];
  logic [15:0] wdata [2];

  mem_bus_ctrl_if bus0();
  mem_bus_ctrl_if bus1();

  assign bus0.cpu_req   = req[0];
  assign bus0.cpu_we    = we[0];
  assign bus0.cpu_addr  = addr[0];
  assign bus0.cpu_wdata = wdata[0];
  assign bus1.cpu_req   = req[1];
  assign bus1.cpu_we    = we[1];
  assign bus1.cpu_addr  = addr[1];
  assign bus1.cpu_wdata = wdata[1];

  mem_bus_ctrl #(.WAIT_CYCLES(3), .IO_ADDR(24'hFFFFFF)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  mem_bus_ctrl #(.WAIT_CYCLES(1), .IO_ADDR(24'hFFFFFF)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // SRAM models: data returned only while oe_n is low, writes need dq_oe.
  logic [15:0] sram0 [256];
  logic [15:0] sram1 [256];
  always @(posedge clk) begin
    if (preload) sram0[8'h00] <= 16'hBEEF;
    else if (!bus0.mem_ce_n && !bus0.mem_we_n)
      sram0[bus0.mem_addr[7:0]] <= bus0.mem_dq_oe ? bus0.mem_dq_out : 16'hBAD0;
  end
  always @(posedge clk) begin
    if (preload) sram1[8'h00] <= 16'hBEEF;
    else if (!bus1.mem_ce_n && !bus1.mem_we_n)
      sram1[bus1.mem_addr[7:0]] <= bus1.mem_dq_oe ? bus1.mem_dq_out : 16'hBAD0;
  end
  assign bus0.mem_dq_in = bus0.mem_oe_n ? 16'hDEAD : sram0[bus0.mem_addr[7:0]];
  assign bus1.mem_dq_in = bus1.mem_oe_n ? 16'hDEAD : sram1[bus1.mem_addr[7:0]];

  int checks = 0;
  int failures = 0;

  int ce_low, oe_low, we_low, dqoe_high, rdy_cnt, rdy_at, viol;
  logic [15:0] rdy_data;

  task automatic start(input int sel, input logic w, input logic [23:0] a, input logic [15:0] d);
    @(negedge clk);
    req[sel] = 1'b1; we[sel] = w; addr[sel] = a; wdata[sel] = d;
    @(posedge clk);
  endtask

  // Cycle k of the loop is the cycle after edge N+k; req drops right after edge N.
  task automatic observe(input int sel, input int n);
    logic ce_n, oe_n, we_n, dq_oe, rdy;
    logic [15:0] rd;
    ce_low = 0; oe_low = 0; we_low = 0; dqoe_high = 0; rdy_cnt = 0; rdy_at = -1; viol = 0;
    rdy_data = 16'h0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) req[sel] = 1'b0;
      ce_n  = sel[0] ? bus1.mem_ce_n  : bus0.mem_ce_n;
      oe_n  = sel[0] ? bus1.mem_oe_n  : bus0.mem_oe_n;
      we_n  = sel[0] ? bus1.mem_we_n  : bus0.mem_we_n;
      dq_oe = sel[0] ? bus1.mem_dq_oe : bus0.mem_dq_oe;
      rdy   = sel[0] ? bus1.cpu_ready : bus0.cpu_ready;
      rd    = sel[0] ? bus1.cpu_rdata : bus0.cpu_rdata;
      if (!ce_n) ce_low++;
      if (!oe_n) oe_low++;
      if (!we_n) we_low++;
      if (dq_oe) dqoe_high++;
      if ((!we_n && ce_n) || (!we_n && !oe_n)) viol++;
      if (rdy) begin
        rdy_cnt++;
        if (rdy_at < 0) begin rdy_at = k; rdy_data = rd; end
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if ({bus0.mem_ce_n, bus0.mem_oe_n, bus0.mem_we_n} !== 3'b111) begin failures++; $display("FAIL reset_strobes: got %b expected 111", {bus0.mem_ce_n, bus0.mem_oe_n, bus0.mem_we_n}); end
    checks++; if ({bus0.mem_dq_oe, bus0.cpu_ready} !== 2'b00) begin failures++; $display("FAIL reset_oe_ready: got %b expected 00", {bus0.mem_dq_oe, bus0.cpu_ready}); end
    checks++; if (bus0.mem_addr !== 24'h0 || bus0.mem_dq_out !== 16'h0) begin failures++; $display("FAIL reset_addr_data: got %h/%h expected 0/0", bus0.mem_addr, bus0.mem_dq_out); end
    checks++; if (bus0.cpu_rdata !== 16'h0 || bus0.io_value !== 16'h0) begin failures++; $display("FAIL reset_rdata_io: got %h/%h expected 0/0", bus0.cpu_rdata, bus0.io_value); end
    checks++; if ({bus1.mem_ce_n, bus1.mem_oe_n, bus1.mem_we_n, bus1.mem_dq_oe} !== 4'b1110) begin failures++; $display("FAIL reset_w1_strobes: got %b expected 1110", {bus1.mem_ce_n, bus1.mem_oe_n, bus1.mem_we_n, bus1.mem_dq_oe}); end
    reset = 1'b0;
  endtask

  task automatic test_read;
    start(0, 1'b0, 24'h002400, 16'h0);
    observe(0, 8);
    checks++; if (ce_low !== 3 || oe_low !== 3) begin failures++; $display("FAIL read_strobe_len: got ce=%0d oe=%0d expected 3/3", ce_low, oe_low); end
    checks++; if (we_low !== 0 || dqoe_high !== 0) begin failures++; $display("FAIL read_no_write: got we=%0d dqoe=%0d expected 0/0", we_low, dqoe_high); end
    checks++; if (rdy_cnt !== 1 || rdy_at !== 4) begin failures++; $display("FAIL read_ready: got cnt=%0d at=%0d expected 1 at 4", rdy_cnt, rdy_at); end
    checks++; if (rdy_data !== 16'hBEEF) begin failures++; $display("FAIL read_data: got %h expected beef", rdy_data); end
    checks++; if (bus0.mem_addr !== 24'h002400) begin failures++; $display("FAIL read_addr_hold: got %h expected 002400", bus0.mem_addr); end
  endtask

  task automatic test_write;
    start(0, 1'b1, 24'h000010, 16'h1234);
    observe(0, 8);
    checks++; if (we_low !== 3 || dqoe_high !== 4) begin failures++; $display("FAIL write_strobe_len: got we=%0d dqoe=%0d expected 3/4", we_low, dqoe_high); end
    checks++; if (ce_low !== 4 || oe_low !== 0) begin failures++; $display("FAIL write_ce_oe: got ce=%0d oe=%0d expected 4/0", ce_low, oe_low); end
    checks++; if (viol !== 0) begin failures++; $display("FAIL write_strobe_overlap: got %0d cycles expected 0", viol); end
    checks++; if (rdy_cnt !== 1 || rdy_at !== 5) begin failures++; $display("FAIL write_ready: got cnt=%0d at=%0d expected 1 at 5", rdy_cnt, rdy_at); end
    start(0, 1'b0, 24'h000010, 16'h0);
    observe(0, 8);
    checks++; if (rdy_at !== 4 || rdy_data !== 16'h1234) begin failures++; $display("FAIL write_readback: got %h at %0d expected 1234 at 4", rdy_data, rdy_at); end
  endtask

  task automatic test_io;
    start(0, 1'b1, 24'hFFFFFF, 16'h00A5);
    observe(0, 4);
    checks++; if (ce_low !== 0 || oe_low !== 0 || we_low !== 0 || dqoe_high !== 0) begin failures++; $display("FAIL io_no_strobe: got ce=%0d oe=%0d we=%0d dqoe=%0d expected all 0", ce_low, oe_low, we_low, dqoe_high); end
    checks++; if (rdy_cnt !== 1 || rdy_at !== 1) begin failures++; $display("FAIL io_write_ready: got cnt=%0d at=%0d expected 1 at 1", rdy_cnt, rdy_at); end
    checks++; if (bus0.io_value !== 16'h00A5) begin failures++; $display("FAIL io_value: got %h expected 00a5", bus0.io_value); end
    checks++; if (bus0.mem_addr !== 24'h000010) begin failures++; $display("FAIL io_addr_untouched: got %h expected 000010", bus0.mem_addr); end
    start(0, 1'b0, 24'hFFFFFF, 16'h0);
    observe(0, 4);
    checks++; if (rdy_at !== 1 || rdy_data !== 16'h00A5) begin failures++; $display("FAIL io_read: got %h at %0d expected 00a5 at 1", rdy_data, rdy_at); end
  endtask

  task automatic test_back_to_back;
    int r0, r1, n_rdy, wl;
    logic [15:0] d0, d1;
    r0 = -1; r1 = -1; n_rdy = 0; wl = 0; d0 = 16'h0; d1 = 16'h0;
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 24'h002400; wdata[0] = 16'h0;
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 1) begin addr[0] = 24'h000010; we[0] = 1'b1; wdata[0] = 16'hFFFF; end
      if (k == 3) we[0] = 1'b0;
      if (k == 5) req[0] = 1'b0;
      if (!bus0.mem_we_n) wl++;
      if (bus0.cpu_ready) begin
        n_rdy++;
        if (r0 < 0) begin r0 = k; d0 = bus0.cpu_rdata; end
        else begin r1 = k; d1 = bus0.cpu_rdata; end
      end
    end
    checks++; if (n_rdy !== 2 || r0 !== 4 || r1 !== 9) begin failures++; $display("FAIL b2b_ready_spacing: got n=%0d at %0d,%0d expected 2 at 4,9", n_rdy, r0, r1); end
    checks++; if (d0 !== 16'hBEEF || d1 !== 16'h1234) begin failures++; $display("FAIL b2b_data: got %h,%h expected beef,1234", d0, d1); end
    checks++; if (wl !== 0) begin failures++; $display("FAIL b2b_ignored_inputs: got we_low=%0d expected 0", wl); end
  endtask

  task automatic test_reset_mid_write;
    start(0, 1'b1, 24'h000020, 16'h5555);
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({bus0.mem_ce_n, bus0.mem_oe_n, bus0.mem_we_n, bus0.mem_dq_oe} !== 4'b1110) begin failures++; $display("FAIL rst_mid_strobes: got %b expected 1110", {bus0.mem_ce_n, bus0.mem_oe_n, bus0.mem_we_n, bus0.mem_dq_oe}); end
    checks++; if (bus0.io_value !== 16'h0 || bus0.cpu_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_io_ready: got %h/%b expected 0000/0", bus0.io_value, bus0.cpu_ready); end
    reset = 1'b0;
    observe(0, 6);
    checks++; if (rdy_cnt !== 0 || ce_low !== 0) begin failures++; $display("FAIL rst_mid_abandon: got ready=%0d ce_low=%0d expected 0/0", rdy_cnt, ce_low); end
    start(0, 1'b0, 24'h002400, 16'h0);
    observe(0, 8);
    checks++; if (rdy_at !== 4 || rdy_data !== 16'hBEEF) begin failures++; $display("FAIL rst_mid_next_read: got %h at %0d expected beef at 4", rdy_data, rdy_at); end
  endtask

  task automatic test_wait_one;
    start(1, 1'b0, 24'h002400, 16'h0);
    observe(1, 6);
    checks++; if (oe_low !== 1 || rdy_cnt !== 1 || rdy_at !== 2 || rdy_data !== 16'hBEEF) begin failures++; $display("FAIL w1_read: got oe=%0d cnt=%0d at=%0d data=%h expected 1,1,2,beef", oe_low, rdy_cnt, rdy_at, rdy_data); end
    start(1, 1'b1, 24'h000030, 16'hCAFE);
    observe(1, 6);
    checks++; if (we_low !== 1 || dqoe_high !== 2 || rdy_cnt !== 1 || rdy_at !== 3) begin failures++; $display("FAIL w1_write: got we=%0d dqoe=%0d cnt=%0d at=%0d expected 1,2,1,3", we_low, dqoe_high, rdy_cnt, rdy_at); end
    start(1, 1'b0, 24'h000030, 16'h0);
    observe(1, 6);
    checks++; if (rdy_at !== 2 || rdy_data !== 16'hCAFE) begin failures++; $display("FAIL w1_readback: got %h at %0d expected cafe at 2", rdy_data, rdy_at); end
  endtask

  initial begin
    reset = 1'b1; preload = 1'b1; req = 2'b00; we = 2'b00;
    addr[0] = 24'h0; addr[1] = 24'h0; wdata[0] = 16'h0; wdata[1] = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    test_reset;
    test_read;
    test_write;
    test_io;
    test_back_to_back;
    test_reset_mid_write;
    test_wait_one;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
